// File: rtl/writeback_queue_if.sv
// Bundles the writeback queue's request, register-file write and forwarding signals.
// Latency: none, wires only.
// Backpressure: stall travels from the queue (slave) back to the request sources (master).
//
// Port summary:
//   load_valid/load_register/load_data : load-unit write request
//   alu_valid/alu_register/alu_data    : ALU write request
//   stall                              : queue nearly full, sources must hold
//   write_switch/write_register/write_data : register file write port (head entry)
//   fwd_register_N / fwd_hit_N / fwd_data_N : forwarding lookups into queued entries
interface writeback_queue_if;
    logic        load_valid;
    logic [4:0]  load_register;
    logic [31:0] load_data;
    logic        alu_valid;
    logic [4:0]  alu_register;
    logic [31:0] alu_data;
    logic        stall;
    logic        write_switch;
    logic [4:0]  write_register;
    logic [31:0] write_data;
    logic [4:0]  fwd_register_1;
    logic [4:0]  fwd_register_2;
    logic        fwd_hit_1;
    logic        fwd_hit_2;
    logic [31:0] fwd_data_1;
    logic [31:0] fwd_data_2;

    modport master (
        output load_valid, load_register, load_data,
        output alu_valid, alu_register, alu_data,
        output fwd_register_1, fwd_register_2,
        input  stall, write_switch, write_register, write_data,
        input  fwd_hit_1, fwd_hit_2, fwd_data_1, fwd_data_2
    );

    modport slave (
        input  load_valid, load_register, load_data,
        input  alu_valid, alu_register, alu_data,
        input  fwd_register_1, fwd_register_2,
        output stall, write_switch, write_register, write_data,
        output fwd_hit_1, fwd_hit_2, fwd_data_1, fwd_data_2
    );
endinterface

// File: rtl/writeback_queue.sv
// Circular writeback queue merging load and ALU register writes onto one register-file port, with forwarding.
// Latency: a write accepted at edge N drives the write port in cycle N+1 and retires at edge N+1.
// Backpressure: stall is raised when fewer than two entries are free; requests seen under stall are ignored.
//
// Port summary:
//   clk   : clock, rising edge
//   reset : asynchronous, active-low
//   bus   : request / write-port / forwarding signals (slave side)
//   count : number of occupied entries
module writeback_queue #(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    writeback_queue_if.slave       bus,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]    head;
    logic [AW-1:0]    tail;
    logic [DEPTH-1:0] entry_valid;
    logic [4:0]       entry_reg  [DEPTH];
    logic [31:0]      entry_data [DEPTH];

    logic          stall;
    logic          load_push;
    logic          alu_push;
    logic          pop;
    logic [1:0]    push_cnt;
    logic [AW-1:0] alu_slot;

    // Stall leaves room for two pushes, so the queue can never overflow.
    assign stall     = count > CW'(DEPTH - 2);
    assign load_push = bus.load_valid && (bus.load_register != 5'd0) && !stall;
    assign alu_push  = bus.alu_valid && (bus.alu_register != 5'd0) && !stall;
    assign pop       = (count != '0);
    assign push_cnt  = {1'b0, load_push} + {1'b0, alu_push};
    // The load entry takes the tail slot first, so the ALU entry is the younger one.
    assign alu_slot  = tail + AW'(load_push);

    assign bus.stall          = stall;
    assign bus.write_switch   = pop;
    assign bus.write_register = (pop && entry_valid[head]) ? entry_reg[head]  : 5'd0;
    assign bus.write_data     = (pop && entry_valid[head]) ? entry_data[head] : 32'd0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            entry_valid <= '0;
        end else begin
            // Push slots are always free while not stalled, so they never collide with the head.
            if (pop) begin
                entry_valid[head] <= 1'b0;
                head              <= head + 1'b1;
            end
            if (load_push) entry_valid[tail]     <= 1'b1;
            if (alu_push)  entry_valid[alu_slot] <= 1'b1;
            tail  <= tail + AW'(push_cnt);
            count <= count + CW'(push_cnt) - CW'(pop);
        end
    end

    // Payload needs no reset: every read of it is masked by entry_valid.
    always_ff @(posedge clk) begin
        if (load_push) begin
            entry_reg[tail]  <= bus.load_register;
            entry_data[tail] <= bus.load_data;
        end
        if (alu_push) begin
            entry_reg[alu_slot]  <= bus.alu_register;
            entry_data[alu_slot] <= bus.alu_data;
        end
    end

    // Walk oldest to youngest from the head; a later match overwrites an
    // earlier one, so the youngest matching entry wins.
    always_comb begin
        logic [AW-1:0] idx;
        idx            = '0;
        bus.fwd_hit_1  = 1'b0;
        bus.fwd_hit_2  = 1'b0;
        bus.fwd_data_1 = 32'd0;
        bus.fwd_data_2 = 32'd0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + AW'(i);
            if (entry_valid[idx] && (bus.fwd_register_1 != 5'd0) &&
                (entry_reg[idx] == bus.fwd_register_1)) begin
                bus.fwd_hit_1  = 1'b1;
                bus.fwd_data_1 = entry_data[idx];
            end
            if (entry_valid[idx] && (bus.fwd_register_2 != 5'd0) &&
                (entry_reg[idx] == bus.fwd_register_2)) begin
                bus.fwd_hit_2  = 1'b1;
                bus.fwd_data_2 = entry_data[idx];
            end
        end
    end
endmodule

// File: tb/tb_writeback_queue.sv
// Scoreboard bench for writeback_queue (DEPTH=4): stimulus queues expected writes,
// a negedge monitor pops and compares every register-file write.
module tb_writeback_queue;
    localparam int DEPTH = 4;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    writeback_queue_if bus ();
    logic [$clog2(DEPTH):0] count;

    writeback_queue #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .count (count)
    );

    typedef struct packed {
        logic [4:0]  r;
        logic [31:0] d;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int  n_checks  = 0;
    int  n_pass    = 0;
    int  model_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    endtask

    // Monitor: every write-port cycle must match the oldest expected write.
    always @(negedge clk) begin
        if (reset && bus.write_switch) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", 32'(bus.write_switch), 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("write_register", 32'(bus.write_register), 32'(mon_e.r));
                check("write_data", bus.write_data, mon_e.d);
            end
        end
    end

    // One cycle of requests; the occupancy model decides acceptance.
    task automatic step(input logic lv, input logic [4:0] lr, input logic [31:0] ld,
                        input logic av, input logic [4:0] ar, input logic [31:0] ad);
        int pushes;
        bit acc;
        pushes = 0;
        acc = (model_cnt <= DEPTH - 2);
        bus.load_valid    = lv;
        bus.load_register = lr;
        bus.load_data     = ld;
        bus.alu_valid     = av;
        bus.alu_register  = ar;
        bus.alu_data      = ad;
        check("stall", 32'(bus.stall), 32'(!acc));
        if (acc && lv && lr != 5'd0) begin exp_q.push_back({lr, ld}); pushes++; end
        if (acc && av && ar != 5'd0) begin exp_q.push_back({ar, ad}); pushes++; end
        model_cnt = model_cnt + pushes - ((model_cnt != 0) ? 1 : 0);
        @(posedge clk);
        #1;
        bus.load_valid = 1'b0;
        bus.alu_valid  = 1'b0;
    endtask

    task automatic idle();
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    initial begin
        bus.load_valid     = 1'b0;
        bus.load_register  = 5'd0;
        bus.load_data      = 32'd0;
        bus.alu_valid      = 1'b0;
        bus.alu_register   = 5'd0;
        bus.alu_data       = 32'd0;
        bus.fwd_register_1 = 5'd0;
        bus.fwd_register_2 = 5'd0;

        // Reset state
        #1;
        check("rst_count", 32'(count), 32'd0);
        check("rst_write_switch", 32'(bus.write_switch), 32'd0);
        check("rst_stall", 32'(bus.stall), 32'd0);
        check("rst_fwd_hit_1", 32'(bus.fwd_hit_1), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        // Single write
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hDEADBEEF);
        check("single_ws", 32'(bus.write_switch), 32'd1);
        check("single_reg", 32'(bus.write_register), 32'd5);
        check("single_data", bus.write_data, 32'hDEADBEEF);
        check("single_count", 32'(count), 32'd1);
        idle();
        check("single_ws_after", 32'(bus.write_switch), 32'd0);
        check("single_count_after", 32'(count), 32'd0);
        check("empty_wdata", bus.write_data, 32'd0);

        // Dual enqueue to the same register: ALU entry is younger
        step(1'b1, 5'd3, 32'h11, 1'b1, 5'd3, 32'h22);
        bus.fwd_register_1 = 5'd3;
        bus.fwd_register_2 = 5'd7;
        #1;
        check("dual_count", 32'(count), 32'd2);
        check("dual_hit_1", 32'(bus.fwd_hit_1), 32'd1);
        check("dual_data_1", bus.fwd_data_1, 32'h22);
        check("dual_hit_2", 32'(bus.fwd_hit_2), 32'd0);
        check("dual_data_2", bus.fwd_data_2, 32'd0);
        idle();
        check("dual_head_hit", 32'(bus.fwd_hit_1), 32'd1);
        check("dual_head_data", bus.fwd_data_1, 32'h22);
        idle();
        check("dual_drained_hit", 32'(bus.fwd_hit_1), 32'd0);
        check("dual_drained_data", bus.fwd_data_1, 32'd0);

        // Register 0 discarded
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h55);
        check("r0_count", 32'(count), 32'd0);
        check("r0_ws", 32'(bus.write_switch), 32'd0);
        step(1'b1, 5'd0, 32'h66, 1'b1, 5'd9, 32'h99);
        bus.fwd_register_1 = 5'd0;
        #1;
        check("r0_mixed_count", 32'(count), 32'd1);
        check("r0_fwd_hit", 32'(bus.fwd_hit_1), 32'd0);
        idle();

        // Fill to stall, drop under stall, then wrap the pointers
        step(1'b1, 5'd1, 32'hA1, 1'b1, 5'd2, 32'hA2);
        check("full_count_2", 32'(count), 32'd2);
        step(1'b1, 5'd3, 32'hA3, 1'b1, 5'd4, 32'hA4);
        check("full_count_3", 32'(count), 32'd3);
        check("full_stall", 32'(bus.stall), 32'd1);
        step(1'b1, 5'd5, 32'hBAD, 1'b1, 5'd6, 32'hBAD);
        check("full_dropped_count", 32'(count), 32'd2);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 5'(10 + i), 32'h100 + i, 1'b1, 5'(20 + i), 32'h200 + i);
            check("wrap_count", 32'(count), 32'(model_cnt));
        end
        for (int i = 0; i < 10 && model_cnt != 0; i++) begin
            idle();
            check("drain_count", 32'(count), 32'(model_cnt));
        end

        // Asynchronous reset with three entries queued
        step(1'b1, 5'd7, 32'h70, 1'b1, 5'd8, 32'h80);
        step(1'b1, 5'd9, 32'h90, 1'b1, 5'd11, 32'hB0);
        bus.fwd_register_1 = 5'd9;
        #1;
        check("pre_rst_count", 32'(count), 32'd3);
        check("pre_rst_hit", 32'(bus.fwd_hit_1), 32'd1);
        check("pre_rst_data", bus.fwd_data_1, 32'h90);
        #1 reset = 1'b0;
        exp_q.delete();
        model_cnt = 0;
        #1;
        check("async_rst_count", 32'(count), 32'd0);
        check("async_rst_ws", 32'(bus.write_switch), 32'd0);
        check("async_rst_stall", 32'(bus.stall), 32'd0);
        check("async_rst_hit", 32'(bus.fwd_hit_1), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check("post_rst_ws", 32'(bus.write_switch), 32'd0);
            idle();
        end

        // Steady push/pop: one write in flight, retired the cycle after acceptance
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 5'd0, 32'd0, 1'b1, 5'(i + 1), 32'hC0 + i);
            check("pp_count", 32'(count), 32'd1);
            check("pp_reg", 32'(bus.write_register), 32'(i + 1));
        end
        idle();
        check("pp_final_count", 32'(count), 32'd0);

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/writeback_queue.md
WRITEBACK_QUEUE -- requirements
Module: writeback_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of queue entries; legal values 4, 8 and 16.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-low; low clears all state immediately.
REQ-004 load_valid  input  1  load unit presents a register write this cycle.
REQ-005 load_register  input  5  destination register of the load write.
REQ-006 load_data  input  32  data of the load write.
REQ-007 alu_valid  input  1  ALU stage presents a register write this cycle.
REQ-008 alu_register  input  5  destination register of the ALU write.
REQ-009 alu_data  input  32  data of the ALU write.
REQ-010 stall  output  1  high when fewer than 2 entries are free; upstream must hold requests.
REQ-011 write_switch  output  1  write enable to the register file write port.
REQ-012 write_register  output  5  register file write address.
REQ-013 write_data  output  32  register file write data.
REQ-014 fwd_register_1, fwd_register_2  input  5 each  read addresses to look up in the queue.
REQ-015 fwd_hit_1, fwd_hit_2  output  1 each  a queued entry matches the corresponding address.
REQ-016 fwd_data_1, fwd_data_2  output  32 each  data of the matching entry; 0 when no hit.
REQ-017 count  output  $clog2(DEPTH)+1  number of occupied entries.

Function
REQ-018 The queue SHALL be a circular FIFO with head and tail pointers that wrap modulo DEPTH, plus a per-entry valid bit.
REQ-019 Enqueue SHALL occur at a rising edge for each source whose valid is high while stall is low.
REQ-020 Requests presented while stall is high SHALL be ignored and SHALL not alter state.
REQ-021 Requests with destination register 0 SHALL be discarded and SHALL not consume an entry.
REQ-022 When both sources enqueue at the same edge, the load entry SHALL be placed before the ALU entry, so the ALU entry is younger.
REQ-023 write_switch SHALL equal (count != 0), and write_register/write_data SHALL show the head entry combinationally.
REQ-024 The head entry SHALL be popped at every rising edge where write_switch is high, giving one write per cycle.
REQ-025 Push and pop at the same edge SHALL be legal, with next count = count + pushes - pop, where pushes is 0..2.
REQ-026 Latency: a write accepted at edge N into an empty queue SHALL appear on the write port during cycle N+1 and be committed at edge N+1.
REQ-027 stall SHALL be combinational and equal (count > DEPTH-2).
REQ-028 Because of stall, count SHALL never exceed DEPTH, and no overflow path SHALL exist.
REQ-029 Forwarding SHALL compare each fwd_register against all valid entries, including the head.
REQ-030 When several entries match, the youngest matching entry SHALL supply the forwarded data.
REQ-031 Forwarding SHALL ignore that cycle's incoming requests.
REQ-032 fwd_register value 0 SHALL never hit.
REQ-033 Forwarding outputs SHALL be purely combinational from queue state and fwd_register inputs.
REQ-034 With count = 0, write_switch, write_register, write_data, fwd_hit_* and fwd_data_* SHALL all be 0.

Reset
REQ-035 While reset is low, the block SHALL clear head, tail, count and all valid bits.
REQ-036 While reset is low, write_switch, stall and all fwd_hit_* outputs SHALL be 0.
REQ-037 Entry data SHALL need no reset, but SHALL be masked by valid so outputs read 0.
REQ-038 Reset asserted mid-operation SHALL discard all pending writes, and no write_switch pulse SHALL follow release.
REQ-039 The first enqueue SHALL occur at the first rising edge after reset goes high.

Verification
REQ-040 Single write: alu_valid=1, alu_register=5, alu_data=0xDEADBEEF for one cycle -> next cycle write_switch=1, write_register=5, write_data=0xDEADBEEF; the cycle after, write_switch=0 and count=0.
REQ-041 Dual enqueue: load (r3, 0x11) and alu (r3, 0x22) at the same edge -> fwd_register_1=3 gives hit with 0x22; write port shows r3=0x11 then r3=0x22 in consecutive cycles.
REQ-042 Register 0: alu_valid with alu_register=0 -> count stays 0 and write_switch stays 0; fwd_register_1=0 never hits.
REQ-043 Full/stall (DEPTH=4): 2 writes per cycle for 2 cycles -> stall=1 when count>=3; a request offered while stall=1 is dropped; drain order is preserved; pointers wrap correctly over more than 8 entries.
REQ-044 Reset mid-operation: with 3 entries queued, pull reset low asynchronously between edges -> count=0 and write_switch=0 immediately; after release, no stale writes appear.
REQ-045 Simultaneous push/pop: hold one push per cycle for 10 cycles -> count stays 1, and each write appears exactly one cycle after it is accepted.
